// File: rtl/ifq_pkg.sv
// ----------------------------------------------------------------------------
// ifq_pkg
// Shared types and constants for the IF/ID decoupling queue.
//   IFQ_IW      : instruction width (bits)
//   IFQ_AW      : PC width (bits)
//   ifq_entry_t : one queued {pc, instr} pair
// ----------------------------------------------------------------------------
package ifq_pkg;

  localparam int IFQ_IW = 9;
  localparam int IFQ_AW = 8;

  typedef struct packed {
    logic [IFQ_AW-1:0] pc;
    logic [IFQ_IW-1:0] instr;
  } ifq_entry_t;

endpackage : ifq_pkg

// File: rtl/ifq_storage.sv
// ----------------------------------------------------------------------------
// ifq_storage
// DEPTH x ifq_entry_t register array. Synchronous write port, asynchronous
// (combinational) read port. Contents carry no reset: the top module's
// occupancy count decides which entries are meaningful.
// Ports:
//   clk_i    : rising-edge clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : read data (combinational from raddr_i)
// ----------------------------------------------------------------------------
module ifq_storage
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [PW-1:0] waddr_i,
  input  ifq_entry_t    wdata_i,
  input  logic [PW-1:0] raddr_i,
  output ifq_entry_t    rdata_o
);

  ifq_entry_t mem_q [DEPTH];

  // Write port: capture one entry per accepted push.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule : ifq_storage

// File: rtl/if_id_queue.sv
// ----------------------------------------------------------------------------
// if_id_queue
// FIFO between fetch and decode. Holds {PC, instruction} pairs, presents the
// head over a valid/ready handshake, back-pressures fetch via fetch_stall and
// drops all entries on flush (taken branch / jump redirect).
// Configuration macro: IFQ_BYPASS_EN -- when defined, an empty queue forwards
// in_pc/in_instr combinationally to the outputs (zero-cycle latency).
// AW/IW must match IFQ_AW/IFQ_IW of ifq_pkg (entries use ifq_entry_t).
// Ports:
//   CLK, RST_N            : clock, async active-low reset
//   in_valid/in_ready     : push handshake from fetch
//   in_pc, in_instr       : pushed pair
//   flush                 : discard all entries (wins over push and pop)
//   out_valid/out_ready   : pop handshake to decode
//   out_pc, out_instr     : head pair (0 when nothing valid)
//   count                 : occupancy
//   fetch_stall           : !in_ready, IF halt
// ----------------------------------------------------------------------------
module if_id_queue
  import ifq_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IW    = IFQ_IW,
  parameter int AW    = IFQ_AW,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH) + 1
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          in_valid,
  input  logic [AW-1:0] in_pc,
  input  logic [IW-1:0] in_instr,
  output logic          in_ready,
  input  logic          flush,
  output logic          out_valid,
  output logic [AW-1:0] out_pc,
  output logic [IW-1:0] out_instr,
  input  logic          out_ready,
  output logic [CW-1:0] count,
  output logic          fetch_stall
);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic       empty_s;
  logic       byp_s;       // empty queue forwarding the incoming pair
  logic       byp_take_s;  // forwarded pair consumed, never stored
  logic       push_s;
  logic       pop_s;
  ifq_entry_t wdata_s;
  ifq_entry_t rdata_s;

  assign empty_s  = (count_q == {CW{1'b0}});
  assign in_ready = (count_q != CNT_FULL);
  assign fetch_stall = ~in_ready;

`ifdef IFQ_BYPASS_EN
  assign byp_s = empty_s & in_valid & ~flush;
`else
  assign byp_s = 1'b0;
`endif
  assign byp_take_s = byp_s & out_ready;

  // Pop only touches stored entries; a bypassed pair is consumed without one.
  assign pop_s  = ~empty_s & out_ready;
  assign push_s = in_valid & in_ready & ~byp_take_s;

  assign wdata_s.pc    = in_pc;
  assign wdata_s.instr = in_instr;

  ifq_storage #(
    .DEPTH (DEPTH)
  ) u_storage (
    .clk_i   (CLK),
    .we_i    (push_s & ~flush),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata_s)
  );

  // Next-state pointers and occupancy; flush overrides push and pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = {PW{1'b0}};
      rd_ptr_d = {PW{1'b0}};
      count_d  = {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head presentation: stored entry, bypassed input, or zeros.
  always_comb begin
    out_valid = 1'b0;
    out_pc    = {AW{1'b0}};
    out_instr = {IW{1'b0}};
    if (!empty_s) begin
      out_valid = 1'b1;
      out_pc    = rdata_s.pc;
      out_instr = rdata_s.instr;
    end else if (byp_s) begin
      out_valid = 1'b1;
      out_pc    = in_pc;
      out_instr = in_instr;
    end else begin
      out_valid = 1'b0;
    end
  end

  assign count = count_q;

endmodule : if_id_queue

// File: tb/tb_if_id_queue.sv
// ----------------------------------------------------------------------------
// tb_if_id_queue
// Directed-vector bench for if_id_queue with hand-computed expectations.
// Inputs change 2 time units after a rising edge; outputs are checked one
// unit later, well away from the next edge.
// ----------------------------------------------------------------------------
module tb_if_id_queue;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       in_valid;
  logic [7:0] in_pc;
  logic [8:0] in_instr;
  logic       in_ready;
  logic       flush;
  logic       out_valid;
  logic [7:0] out_pc;
  logic [8:0] out_instr;
  logic       out_ready;
  logic [2:0] count;
  logic       fetch_stall;

  int n_checks = 0;
  int n_errors = 0;

  if_id_queue #(.DEPTH(4)) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .in_valid    (in_valid),
    .in_pc       (in_pc),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_pc      (out_pc),
    .out_instr   (out_instr),
    .out_ready   (out_ready),
    .count       (count),
    .fetch_stall (fetch_stall)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs may be changed right after.
  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    RST_N = 1'b0; in_valid = 1'b0; in_pc = 8'h00; in_instr = 9'h000;
    flush = 1'b0; out_ready = 1'b0;

    // Reset then idle
    tick(); tick();
    RST_N = 1'b1;
    settle();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_fetch_stall", 32'(fetch_stall), 32'd0);
    chk("rst_out_pc", 32'(out_pc), 32'd0);
    chk("rst_out_instr", 32'(out_instr), 32'd0);

    // Empty pop attempt is ignored
    out_ready = 1'b1;
    tick();
    chk("empty_pop_count", 32'(count), 32'd0);
    out_ready = 1'b0;

    // Fill: PCs 0..3, instrs 0x101..0x104
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_pc = 8'(i); in_instr = 9'(9'h101 + i);
      tick();
      settle();
      chk("fill_count", 32'(count), 32'(i + 1));
      chk("fill_head_pc", 32'(out_pc), 32'd0);
    end
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_fetch_stall", 32'(fetch_stall), 32'd1);

    // 5th push while full is ignored
    in_pc = 8'd4; in_instr = 9'h105;
    tick();
    settle();
    chk("full_push_count", 32'(count), 32'd4);

    // Drain with in_valid still high: a pop while full opens no slot that cycle
    out_ready = 1'b1;
    settle();
    chk("full_pop_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("drain_pc", 32'(out_pc), 32'(i));
      chk("drain_instr", 32'(out_instr), 32'(9'h101 + i));
      tick();
    end
    settle();
    chk("drain_count", 32'(count), 32'd0);
    chk("drain_out_valid", 32'(out_valid), 32'd0);

    // Steady stream PC 0..9, push and pop every cycle (pointers wrap)
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_pc = 8'(i); in_instr = 9'(9'h040 + i);
      settle();
`ifdef IFQ_BYPASS_EN
      chk("stream_pc", 32'(out_pc), 32'(i));
      tick();
      settle();
      chk("stream_count", 32'(count), 32'd0);
`else
      if (i > 0) begin
        chk("stream_pc", 32'(out_pc), 32'(i - 1));
        chk("stream_instr", 32'(out_instr), 32'(9'h040 + i - 1));
      end
      tick();
      settle();
      chk("stream_count", 32'(count), 32'd1);
`endif
    end
    in_valid = 1'b0;
`ifndef IFQ_BYPASS_EN
    settle();
    chk("stream_last_pc", 32'(out_pc), 32'd9);
    tick();
`endif
    settle();
    chk("stream_end_count", 32'(count), 32'd0);

    // Flush priority over push and pop
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 8'(8'h10 + i); in_instr = 9'(9'h0A0 + i);
      tick();
    end
    settle();
    chk("pre_flush_count", 32'(count), 32'd3);
    in_pc = 8'h20; in_instr = 9'h0C0; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    settle();
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    tick();
    settle();
    chk("flush_no_ghost", 32'(out_valid), 32'd0);
    // Pointers restart: next push becomes the head
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 8'h30; in_instr = 9'h0D0;
    tick();
    in_valid = 1'b0;
    settle();
    chk("post_flush_pc", 32'(out_pc), 32'h30);
    chk("post_flush_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Async reset mid-operation
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 8'(8'h50 + i); in_instr = 9'(9'h050 + i);
      tick();
    end
    in_valid = 1'b0;
    settle();
    chk("pre_arst_count", 32'(count), 32'd2);
    RST_N = 1'b0;
    settle();
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_out_pc", 32'(out_pc), 32'd0);
    tick();
    RST_N = 1'b1;
    tick();

    // Bypass / minimum latency through an empty queue
    in_valid = 1'b1; in_pc = 8'h07; in_instr = 9'h1FF; out_ready = 1'b1;
    settle();
`ifdef IFQ_BYPASS_EN
    chk("byp_out_valid", 32'(out_valid), 32'd1);
    chk("byp_out_pc", 32'(out_pc), 32'h07);
    chk("byp_out_instr", 32'(out_instr), 32'h1FF);
    tick();
    in_valid = 1'b0;
    settle();
    chk("byp_count", 32'(count), 32'd0);
`else
    chk("lat_out_valid0", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    settle();
    chk("lat_out_valid1", 32'(out_valid), 32'd1);
    chk("lat_out_pc", 32'(out_pc), 32'h07);
    chk("lat_out_instr", 32'(out_instr), 32'h1FF);
    tick();
    settle();
    chk("lat_count", 32'(count), 32'd0);
`endif
    out_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_if_id_queue

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Decoupling buffer between the fetch stage (IF + InstrROM) and the decode stage.
- Captures each fetched {PC, 9-bit instruction} pair into a small FIFO and presents it to decode over a valid/ready handshake.
- Back-pressures fetch through fetch_stall, which IF uses as its halt input.
- Discards all queued entries on a taken branch or jump (flush).

Parameters:
- DEPTH, 4, number of queue entries; power of two, at least 2.
- IW, 9, instruction width in bits.
- AW, 8, PC width in bits.

Ports:
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- in_valid  input  1  fetch presents a valid pair this cycle.
- in_pc  input  AW  PC of the fetched instruction.
- in_instr  input  IW  instruction_out from InstrROM.
- in_ready  output  1  queue accepts a push this cycle.
- flush  input  1  discard all entries (redirect from jump resolution).
- out_valid  output  1  head entry valid.
- out_pc  output  AW  head PC.
- out_instr  output  IW  head instruction.
- out_ready  input  1  decode consumes head this cycle.
- count  output  $clog2(DEPTH)+1  current occupancy.
- fetch_stall  output  1  equals !in_ready; drives IF halt.

Behaviour:
- Reset: asynchronous, on RST_N low.
  - wr_ptr, rd_ptr, count go to 0.
  - out_valid, out_pc, out_instr go to 0; in_ready goes to 1; fetch_stall goes to 0.
  - Storage contents are don't-care.
  - Reset asserted mid-stream drops all entries immediately, with no partial output.
- Push: in_valid && in_ready at the rising edge. Writes {in_pc, in_instr} at wr_ptr, then wr_ptr+1 mod DEPTH.
- Pop: out_valid && out_ready at the rising edge. rd_ptr+1 mod DEPTH.
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- in_ready = (count != DEPTH).
  - When full, a simultaneous pop does not open a slot in the same cycle; in_ready stays 0 until count drops.
- out_valid = (count != 0).
  - out_pc and out_instr are read combinationally from the registered entry at rd_ptr.
  - Both are forced to 0 when count == 0.
- Latency, no bypass: an entry pushed at edge N is visible at the output after edge N and can be popped no earlier than edge N+1.
- Order: strict FIFO; entries are never reordered or duplicated.
- Wrap-around: pointers are log2(DEPTH) bits and wrap naturally. Full and empty are distinguished only by count.
- Flush (synchronous; highest priority over push and pop in the same cycle):
  - At the edge: wr_ptr = rd_ptr = count = 0.
  - Input presented in the flush cycle is dropped, even if in_ready = 1.
  - out_valid falls after that edge.
- Empty pop attempt (out_ready with count == 0): ignored. Full push attempt: ignored, and in_valid data is not captured.
- No internal state machine beyond the occupancy counter.
  - Occupancy states are EMPTY (count = 0), PARTIAL, and FULL (count = DEPTH).
  - Transitions follow the push/pop/flush rules above.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined:
  - When count == 0, in_valid = 1 and flush = 0: out_valid = 1, and out_pc/out_instr equal in_pc/in_instr combinationally.
  - If out_ready is also 1, the pair is consumed directly and not written; count stays 0.
  - Otherwise it is pushed normally.
  - Gives zero-cycle latency through an empty queue.
- Undefined: no combinational in-to-out path; minimum latency is one cycle as above.

Decomposition:
- Package ifq_pkg:
  - Localparams IFQ_IW = 9 and IFQ_AW = 8.
  - typedef struct packed { logic [IFQ_AW-1:0] pc; logic [IFQ_IW-1:0] instr; } ifq_entry_t.
- One natural sub-module: ifq_storage, a DEPTH x ifq_entry_t register array with a synchronous write port and an asynchronous read port.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset then idle: RST_N = 0 for 2 cycles, release → count = 0, out_valid = 0, in_ready = 1, fetch_stall = 0, out_pc = 0.
- Fill and drain: push PCs 0..3 with instrs 9'h101..9'h104, out_ready = 0.
  - After the 4th push: count = 4, in_ready = 0, fetch_stall = 1.
  - A 5th push (PC = 4) is ignored.
  - Then out_ready = 1 for 4 cycles → out_pc sequence 0, 1, 2, 3; count ends at 0.
- Steady stream with wrap: push and pop every cycle for 10 cycles, PC 0..9 → count stays 1 after the first push, outputs appear in order 0..9, pointers wrap twice.
- Flush priority: with count = 3, assert flush together with in_valid (PC = 8'h20) and out_ready.
  - Next cycle: count = 0, out_valid = 0.
  - PC 8'h20 is never output.
- Async reset mid-operation: with count = 2, drop RST_N between clock edges → out_valid = 0 and count = 0 before the next edge.
- Bypass (IFQ_BYPASS_EN defined): queue empty, in_valid = 1, PC = 8'h07, instr = 9'h1FF, out_ready = 1.
  - Same cycle: out_valid = 1, out_pc = 8'h07, out_instr = 9'h1FF.
  - Next cycle: count = 0.
  - Without the macro: out_valid = 0 in the first cycle and 1 in the second.
